hls_handshake_profiler: RTL

Synthesizable, parametrised profiler for N_CH HLS block-level handshake channels (ap_start/ap_ready/ap_done/ap_continue plus a pipelined-loop iteration strobe). Per channel, it tracks the transaction state and accumulates these statistics:

- completed transactions
- busy cycles
- continue-stall cycles
- loop iterations
- last, min and max latency

The statistics are read through a registered indexed read port. It sits beside the accelerator top (e.g. the bgn_inference core and its LAYER pipelines), so on-board runs get the same module- and loop-status data the simulation dumps produce.

---
 rtl/hls_handshake_profiler.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/hls_handshake_profiler.sv
// hls_handshake_profiler: per-channel HLS block handshake tracker with saturating
// statistics counters and a registered indexed read port.
`default_nettype none

module hls_handshake_profiler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             finish,
    input  logic             clear,
    input  logic [N_CH-1:0]  ap_start,
    input  logic [N_CH-1:0]  ap_ready,
    input  logic [N_CH-1:0]  ap_done,
    input  logic [N_CH-1:0]  ap_continue,
    input  logic [N_CH-1:0]  iter_end,
    input  logic             rd_en,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    logic [N_CH-1:0][CNT_W-1:0] txn_a, busy_a, stall_a, iter_a, last_a, min_a, max_a;
    logic [N_CH-1:0][3:0]       stat_a;

    // ap_ready is observed only; folded here so it is visibly consumed
    logic w_unused_ready;
    assign w_unused_ready = ^ap_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] lat_q, lat_d, lat_inc, latency;
        logic [CNT_W-1:0] txn_q, txn_d, busy_q, busy_d, stall_q, stall_d, iter_q, iter_d;
        logic [CNT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
        logic             sat_q, sat_d, perr_q, perr_d;
        logic             done_ev, busy_ev, stall_ev, perr_ev, lat_ovf;

        assign lat_inc = (&lat_q) ? lat_q : lat_q + CNT_W'(1);

        always_comb begin
            state_d  = state_q;
            lat_d    = lat_q;
            latency  = lat_inc;
            done_ev  = 1'b0;
            busy_ev  = 1'b0;
            stall_ev = 1'b0;
            perr_ev  = 1'b0;
            lat_ovf  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (ap_start[g]) begin
                        busy_ev = 1'b1;
                        lat_d   = CNT_W'(1);
                        latency = CNT_W'(1);
                        if (ap_done[g]) begin
                            done_ev = 1'b1;
                            state_d = ap_continue[g] ? IDLE : DWAIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (ap_done[g]) begin
                        perr_ev = 1'b1;
                    end
                end
                RUN: begin
                    busy_ev = 1'b1;
                    lat_ovf = &lat_q;
                    if (ap_done[g]) begin
                        done_ev = 1'b1;
                        if (ap_continue[g]) begin
                            if (ap_start[g]) begin
                                state_d = RUN;
                                lat_d   = CNT_W'(1);
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = DWAIT;
                        end
                    end else begin
                        lat_d = lat_inc;
                    end
                end
                DWAIT: begin
                    stall_ev = 1'b1;
                    if (ap_continue[g]) begin
                        if (ap_start[g]) begin
                            state_d = RUN;
                            lat_d   = CNT_W'(1);
                            busy_ev = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // clear wins over finish; the FSM and lat above are never affected by either
        always_comb begin
            txn_d   = txn_q;
            busy_d  = busy_q;
            stall_d = stall_q;
            iter_d  = iter_q;
            last_d  = last_q;
            min_d   = min_q;
            max_d   = max_q;
            sat_d   = sat_q;
            perr_d  = perr_q;
            if (clear) begin
                txn_d   = '0;
                busy_d  = '0;
                stall_d = '0;
                iter_d  = '0;
                last_d  = '0;
                min_d   = '1;
                max_d   = '0;
                sat_d   = 1'b0;
                perr_d  = 1'b0;
            end else if (!finish) begin
                txn_d   = sat_inc(txn_q, done_ev);
                busy_d  = sat_inc(busy_q, busy_ev);
                stall_d = sat_inc(stall_q, stall_ev);
                iter_d  = sat_inc(iter_q, iter_end[g]);
                if (done_ev) begin
                    last_d = latency;
                    if (latency < min_q) min_d = latency;
                    if (latency > max_q) max_d = latency;
                end
                if ((done_ev && (&txn_q)) || (busy_ev && (&busy_q)) ||
                    (stall_ev && (&stall_q)) || (iter_end[g] && (&iter_q)) || lat_ovf)
                    sat_d = 1'b1;
                if (perr_ev) perr_d = 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= IDLE;
                lat_q   <= '0;
                txn_q   <= '0;
                busy_q  <= '0;
                stall_q <= '0;
                iter_q  <= '0;
                last_q  <= '0;
                min_q   <= '1;
                max_q   <= '0;
                sat_q   <= 1'b0;
                perr_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                lat_q   <= lat_d;
                txn_q   <= txn_d;
                busy_q  <= busy_d;
                stall_q <= stall_d;
                iter_q  <= iter_d;
                last_q  <= last_d;
                min_q   <= min_d;
                max_q   <= max_d;
                sat_q   <= sat_d;
                perr_q  <= perr_d;
            end
        end

        assign txn_a[g]   = txn_q;
        assign busy_a[g]  = busy_q;
        assign stall_a[g] = stall_q;
        assign iter_a[g]  = iter_q;
        assign last_a[g]  = last_q;
        assign min_a[g]   = min_q;
        assign max_a[g]   = max_q;
        assign stat_a[g]  = {perr_q, sat_q, state_q};
    end

    logic [CNT_W-1:0] rd_data_d, rd_data_q;
    logic             rd_valid_q;
    logic [CNT_W+4:0] stat_wide;

    // out-of-range channels match no index and read as zero
    always_comb begin
        rd_data_d = '0;
        stat_wide = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                stat_wide = {{CNT_W{1'b0}}, finish, stat_a[i]};
                case (rd_sel)
                    3'd0:    rd_data_d = txn_a[i];
                    3'd1:    rd_data_d = busy_a[i];
                    3'd2:    rd_data_d = stall_a[i];
                    3'd3:    rd_data_d = iter_a[i];
                    3'd4:    rd_data_d = last_a[i];
                    3'd5:    rd_data_d = min_a[i];
                    3'd6:    rd_data_d = max_a[i];
                    default: rd_data_d = stat_wide[CNT_W-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire
